// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage for the 5-stage MIPS pipeline.
// Owns the PC, issues fetches over a req/ready handshake with variable
// latency, honours the hazard stall through a one-entry hold buffer and
// absorbs branch/jump redirects. A redirect that lands while a fetch is
// still outstanding waits in DRAIN, so the request is never abandoned.
// Optional build macro: IF_PERF_CNT_EN adds stall_cnt / bubble_cnt.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_newpc,
    output logic        if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] tgt_reg, tgt_next;
    logic [31:0] buf_inst_reg, buf_inst_next;
    logic [31:0] buf_pc_reg, buf_pc_next;
    logic [31:0] if_inst_reg, if_inst_next;
    logic [31:0] if_newpc_reg, if_newpc_next;
    logic        if_valid_reg, if_valid_next;
    logic        write_bubble;
    logic [31:0] pc_step_sum;

    // Sequential address, modulo 2^32 so the top word wraps to zero.
    assign pc_step_sum = pc_reg + PC_STEP;

    // The request is withdrawn only while the buffer holds a stalled
    // instruction or while reset is asserted.
    assign imem_req  = reset && (state_reg != ST_HOLD);
    assign imem_addr = pc_reg;

    assign if_inst  = if_inst_reg;
    assign if_newpc = if_newpc_reg;
    assign if_valid = if_valid_reg;

    // Next-state and stage-output decision; redirect outranks hazard.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        tgt_next      = tgt_reg;
        buf_inst_next = buf_inst_reg;
        buf_pc_next   = buf_pc_reg;
        if_inst_next  = if_inst_reg;
        if_newpc_next = if_newpc_reg;
        if_valid_next = if_valid_reg;
        write_bubble  = 1'b0;

        case (state_reg)
            ST_REQ: begin
                if (imem_ready) begin
                    if (redirect) begin
                        // Returned word is on the wrong path: drop it.
                        pc_next      = redirect_pc;
                        write_bubble = 1'b1;
                    end else if (!hazard) begin
                        if_inst_next  = imem_rdata;
                        if_newpc_next = pc_step_sum;
                        if_valid_next = 1'b1;
                        pc_next       = pc_step_sum;
                    end else begin
                        // IF/ID is frozen: park the word until it frees up.
                        buf_inst_next = imem_rdata;
                        buf_pc_next   = pc_step_sum;
                        pc_next       = pc_step_sum;
                        state_next    = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Fetch still in flight: remember target, finish old one.
                    tgt_next     = redirect_pc;
                    write_bubble = 1'b1;
                    state_next   = ST_DRAIN;
                end else if (!hazard) begin
                    write_bubble = 1'b1;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    buf_inst_next = 32'd0;
                    buf_pc_next   = 32'd0;
                    pc_next       = redirect_pc;
                    write_bubble  = 1'b1;
                    state_next    = ST_REQ;
                end else if (!hazard) begin
                    if_inst_next  = buf_inst_reg;
                    if_newpc_next = buf_pc_reg;
                    if_valid_next = 1'b1;
                    state_next    = ST_REQ;
                end
            end

            ST_DRAIN: begin
                write_bubble = 1'b1;
                if (imem_ready) begin
                    pc_next    = redirect ? redirect_pc : tgt_reg;
                    state_next = ST_REQ;
                end else if (redirect) begin
                    tgt_next = redirect_pc;
                end
            end

            default: begin
                state_next = ST_REQ;
            end
        endcase

        if (write_bubble) begin
            if_inst_next  = 32'd0;
            if_valid_next = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_REQ;
            pc_reg       <= RESET_PC;
            tgt_reg      <= 32'd0;
            buf_inst_reg <= 32'd0;
            buf_pc_reg   <= 32'd0;
            if_inst_reg  <= 32'd0;
            if_newpc_reg <= 32'd0;
            if_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            tgt_reg      <= tgt_next;
            buf_inst_reg <= buf_inst_next;
            buf_pc_reg   <= buf_pc_next;
            if_inst_reg  <= if_inst_next;
            if_newpc_reg <= if_newpc_next;
            if_valid_reg <= if_valid_next;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] bubble_cnt_reg;

    assign stall_cnt  = stall_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_reg  <= 32'd0;
            bubble_cnt_reg <= 32'd0;
        end else begin
            if (hazard) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (write_bubble) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
        end
    end
`endif

endmodule
